// File: rtl/adder_seq_pkg.sv
// Shared types for the byte-serial adder sequencer: FSM state encoding and slice width.
// Optional subtract mode is selected elsewhere by the ADD_SEQ_SUB_EN macro.
package adder_seq_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_seq_ctrl.
// op_sub exists only when ADD_SEQ_SUB_EN is defined.
interface adder_seq_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int WIDTH = adder_seq_pkg::SLICE_W * WORDS;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
`ifdef ADD_SEQ_SUB_EN
    logic             op_sub;
`endif
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_sum;
    logic             result_overflow;

    // Requester side: issues operations and consumes results.
    modport master (
`ifdef ADD_SEQ_SUB_EN
        output op_sub,
`endif
        output start_valid,
        output op_a,
        output op_b,
        output carry_in,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  result_sum,
        input  result_overflow
    );

    // Sequencer side.
    modport slave (
`ifdef ADD_SEQ_SUB_EN
        input  op_sub,
`endif
        input  start_valid,
        input  op_a,
        input  op_b,
        input  carry_in,
        input  result_ready,
        output start_ready,
        output result_valid,
        output result_sum,
        output result_overflow
    );

endinterface

// File: rtl/adder_8bit.sv
// Combinational 8-bit ripple-carry adder; the single datapath reused slice by slice.
module adder_8bit
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] sum,
    output logic               overflow
);

    logic [SLICE_W:0] carry;

    assign carry[0] = carry_in;

    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign overflow = carry[SLICE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Byte-serial WORDS x 8-bit adder: one slice per clock through a shared adder_8bit,
// carry registered between slices. ADD_SEQ_SUB_EN adds an A - B mode via op_sub.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic             clk,
    input  logic             n_rst,
    adder_seq_ctrl_if.slave  bus,
    output logic             busy
);

    localparam int WIDTH = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               ovf_reg;
    logic               start_ready_reg;
    logic               result_valid_reg;
    logic               busy_reg;
`ifdef ADD_SEQ_SUB_EN
    logic               sub_reg;
`endif

    logic [SLICE_W-1:0] a_slices   [WORDS];
    logic [SLICE_W-1:0] b_slices   [WORDS];
    logic [SLICE_W-1:0] sum_slices_reg [WORDS];

    logic [SLICE_W-1:0] adder_a;
    logic [SLICE_W-1:0] adder_b;
    logic [SLICE_W-1:0] adder_sum;
    logic               adder_ovf;
    logic               init_carry;

    // Operand slices come from the captured copies, so the requester may change
    // op_a/op_b as soon as the operation has been accepted.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
        assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
        assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        assign bus.result_sum[gi*SLICE_W +: SLICE_W] = sum_slices_reg[gi];

        always_ff @(posedge clk) begin
            if (!n_rst) begin
                sum_slices_reg[gi] <= '0;
            end else if (state_reg == ADD && idx_reg == IDX_W'(gi)) begin
                sum_slices_reg[gi] <= adder_sum;
            end
        end
    end

    assign adder_a = a_slices[idx_reg];

`ifdef ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; the final carry then reads as "no borrow".
    assign adder_b    = sub_reg ? ~b_slices[idx_reg] : b_slices[idx_reg];
    assign init_carry = bus.op_sub ? 1'b1 : bus.carry_in;
`else
    assign adder_b    = b_slices[idx_reg];
    assign init_carry = bus.carry_in;
`endif

    adder_8bit u_adder (
        .a        (adder_a),
        .b        (adder_b),
        .carry_in (carry_reg),
        .sum      (adder_sum),
        .overflow (adder_ovf)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            carry_reg        <= 1'b0;
            a_reg            <= '0;
            b_reg            <= '0;
            ovf_reg          <= 1'b0;
            start_ready_reg  <= 1'b1;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_reg          <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_reg           <= bus.op_a;
                        b_reg           <= bus.op_b;
                        carry_reg       <= init_carry;
`ifdef ADD_SEQ_SUB_EN
                        sub_reg         <= bus.op_sub;
`endif
                        idx_reg         <= '0;
                        state_reg       <= ADD;
                        start_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end
                ADD: begin
                    carry_reg <= adder_ovf;
                    // Counter parks on the last slice rather than wrapping past WORDS-1.
                    if (idx_reg == LAST_IDX) begin
                        state_reg        <= DONE;
                        ovf_reg          <= adder_ovf;
                        result_valid_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_reg        <= IDLE;
                        result_valid_reg <= 1'b0;
                        start_ready_reg  <= 1'b1;
                        busy_reg         <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    result_valid_reg <= 1'b0;
                    start_ready_reg  <= 1'b1;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready     = start_ready_reg;
    assign bus.result_valid    = result_valid_reg;
    assign bus.result_overflow = ovf_reg;
    assign busy                = busy_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed scoreboard bench for adder_seq_ctrl (WORDS=4); subtract steps run
// only when ADD_SEQ_SUB_EN is defined.
module tb_adder_seq_ctrl;

    localparam int WORDS = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic busy;

    int n_cmp = 0;
    int n_mis = 0;

    // Scoreboard entries: {overflow, sum}
    logic [32:0] exp_q [$];

    adder_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [32:0] exp);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.carry_in    = cin;
        bus.start_valid = 1'b1;
        check("accept_ready", bus.start_ready, 1);
        tick();
        bus.start_valid = 1'b0;
        exp_q.push_back(exp);
        check("accept_busy", busy, 1);
        $display("op issued a=%08h b=%08h cin=%0d expect sum=%08h ovf=%0d",
                 a, b, cin, exp[31:0], exp[32]);
    endtask

    // Waits for result_valid, checks latency and value, holds off result_ready
    // for 'hold' cycles, then completes the handshake.
    task automatic collect(input int hold, input logic mutate);
        int          lat = 0;
        logic [32:0] exp;
        logic [31:0] held;
        bus.result_ready = (hold == 0);
        while (!bus.result_valid && lat < 50) begin
            if (mutate) bus.op_a = bus.op_a ^ 32'hA5A5_5A5A;
            tick();
            lat++;
        end
        check("latency", lat, WORDS);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        check("sum", bus.result_sum, exp[31:0]);
        check("overflow", bus.result_overflow, exp[32]);
        check("done_start_ready", bus.start_ready, 0);
        held = bus.result_sum;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", bus.result_valid, 1);
            check("hold_sum", bus.result_sum, held);
            check("hold_start_ready", bus.start_ready, 0);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("post_valid", bus.result_valid, 0);
        check("post_start_ready", bus.start_ready, 1);
        check("post_busy", busy, 0);
        $display("result sum=%08h ovf=%0d latency=%0d hold=%0d",
                 held, exp[32], lat, hold);
    endtask

    initial begin
        int seen_valid;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.carry_in     = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub       = 1'b0;
`endif
        n_rst = 1'b0;
        repeat (3) tick();
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_sum", bus.result_sum, 0);
        check("rst_ovf", bus.result_overflow, 0);
        n_rst = 1'b1;
        tick();

        offer(32'h0000_0003, 32'h0000_0004, 1'b0, {1'b0, 32'h0000_0007});
        collect(0, 1'b0);

        offer(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000});
        collect(0, 1'b0);

        offer(32'h00FF_00FF, 32'h0001_0001, 1'b1, {1'b0, 32'h0100_0101});
        collect(0, 1'b1);

        // Backpressure: a new request waits while the result is stalled.
        offer(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789});
        bus.op_a        = 32'h0000_0100;
        bus.op_b        = 32'h0000_0200;
        bus.carry_in    = 1'b0;
        bus.start_valid = 1'b1;
        collect(5, 1'b0);
        exp_q.push_back({1'b0, 32'h0000_0300});
        tick();
        bus.start_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        collect(0, 1'b0);

        // Reset during the second ADD cycle discards the operation.
        offer(32'h89AB_CDEF, 32'h0101_0101, 1'b0, {1'b0, 32'h8AAC_CEF0});
        tick();
        n_rst = 1'b0;
        tick();
        void'(exp_q.pop_back());
        check("mid_rst_start_ready", bus.start_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", bus.result_valid, 0);
        check("mid_rst_sum", bus.result_sum, 0);
        check("mid_rst_ovf", bus.result_overflow, 0);
        n_rst = 1'b1;
        seen_valid = 0;
        repeat (6) begin
            tick();
            if (bus.result_valid) seen_valid++;
        end
        check("mid_rst_no_result", seen_valid, 0);
        $display("reset mid-operation: result_valid seen %0d times", seen_valid);

        offer(32'h0000_0010, 32'h0000_0020, 1'b0, {1'b0, 32'h0000_0030});
        collect(0, 1'b0);

`ifdef ADD_SEQ_SUB_EN
        bus.op_sub = 1'b1;
        offer(32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 32'hFFFF_FFFE});
        bus.op_sub = 1'b0;
        collect(0, 1'b0);
        bus.op_sub = 1'b1;
        offer(32'h0000_0007, 32'h0000_0005, 1'b1, {1'b1, 32'h0000_0002});
        bus.op_sub = 1'b0;
        collect(0, 1'b0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
